axis_div_iter: RTL and testbench
================================

# axis_div_iter

In-house iterative 32-bit divider for the EX stage. It implements the responder side of the AXI-Stream divisor/dividend interface that the EX-stage divide wrapper already drives, so it can replace the vendor divider IP. It computes quotient and remainder, signed or unsigned, with a fixed latency. It returns `{quotient, remainder}` on a single AXI-Stream master channel with backpressure support.

## Interface
- `WIDTH`, 32: operand width; quotient and remainder are each `WIDTH` bits.
- `clk`  in  1: the only clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cancel`  in  1: pipeline flush; aborts any in-flight operation.
- `signed_op`  in  1: 1 = signed (DIV/MOD), 0 = unsigned (DIVU/MODU); sampled at acceptance.
- `s_axis_dividend_tdata`  in  WIDTH: dividend.
- `s_axis_dividend_tvalid`  in  1: dividend valid.
- `s_axis_dividend_tready`  out  1: dividend accepted.
- `s_axis_divisor_tdata`  in  WIDTH: divisor.
- `s_axis_divisor_tvalid`  in  1: divisor valid.
- `s_axis_divisor_tready`  out  1: divisor accepted.
- `m_axis_dout_tdata`  out  2*WIDTH: `[63:32]` = quotient, `[31:0]` = remainder.
- `m_axis_dout_tvalid`  out  1: result valid.
- `m_axis_dout_tready`  in  1: consumer ready.

## Operation
- **FSM states:** IDLE, CALC, FIX, DONE.
- **Input readiness.** Both treadys equal `(state==IDLE) & dividend_tvalid & divisor_tvalid & !cancel & !rst`. Both channels are therefore always accepted on the same edge; a single channel is never consumed alone.
- **IDLE → CALC on acceptance:**
  - latch `signed_op` and both raw operands;
  - form magnitudes: absolute value when `signed_op` and the MSB is set, otherwise the raw value;
  - record quotient sign = `sa ^ sb` and remainder sign = `sa`;
  - clear the partial remainder and load the quotient shift register with |dividend|;
  - set iteration counter = 0.
- **CALC (one restoring step per cycle):**
  - shift `{rem, quo}` left by 1;
  - trial = rem − |divisor|, computed at `WIDTH+1` bits;
  - if the trial is non-negative, rem = trial and the new quotient LSB = 1; otherwise the quotient LSB = 0;
  - counter increments; after step `WIDTH` (counter == 31 at the edge) go to FIX.
- **FIX (one cycle), result selection:**
  - divisor == 0: quotient = all ones, remainder = raw dividend, for both signed and unsigned;
  - otherwise: negate the quotient if its sign flag is set, and negate the remainder if its sign flag is set;
  - signed `0x80000000 / 0xFFFFFFFF` yields quotient `0x80000000` and remainder 0 through the natural path; no special case is required.
  - Load `m_axis_dout_tdata`, set tvalid, go to DONE.
- **DONE:**
  - hold tvalid and tdata stable until `m_axis_dout_tready`;
  - on the handshake edge, clear tvalid and go to IDLE;
  - inputs are not accepted during DONE.
- **Cancel:**
  - in CALC or FIX, `cancel` sends the FSM to IDLE on that edge and no result is produced;
  - in IDLE, `cancel` blocks acceptance;
  - in DONE, `cancel` drops tvalid and sends the FSM to IDLE.
- **Reset:** `rst` has priority over `cancel` and every handshake. The FSM goes to IDLE from any state, including mid-CALC.

## Timing
- **Reset values:** state IDLE, `m_axis_dout_tvalid` = 0, `m_axis_dout_tdata` = 0, both s treadys = 0 while `rst` is high.
- **Latency:** acceptance edge E0 → CALC edges E1..E32 → FIX at edge E33 → tvalid visible immediately after E33.
  - Latency is fixed at 33 edges, independent of the operand values and of divide-by-zero.
  - The wrapper's fixed cycle counter must be set to match this latency.
- **Throughput:** the minimum acceptance-to-acceptance interval is 35 edges (33 + handshake + IDLE).
- **tdata stability:** tdata changes only at the FIX edge and at reset.
- **Operand stability:** the operand inputs may change freely after E0.

## Test plan
- **Unsigned divide:** `signed_op`=0, 100 / 7 accepted at E0 → `m_axis_dout_tdata` = `0x0000000E_00000002`; tvalid first high after E33, never before.
- **Signed divide:** `signed_op`=1, `0xFFFFFFF9` (−7) / 2 → tdata = `0xFFFFFFFD_FFFFFFFF` (q=−3, r=−1). Also 7 / −2 → `0xFFFFFFFD_00000001`.
- **Divide by zero:** `0x12345678` / 0, both modes → tdata = `0xFFFFFFFF_12345678`, same 33-edge latency. Signed overflow `0x80000000` / `0xFFFFFFFF` → `0x80000000_00000000`.
- **Backpressure:**
  - hold `m_axis_dout_tready`=0 for 5 cycles after tvalid → tdata and tvalid remain constant;
  - new input valids stay high throughout → treadys remain 0 until the FSM returns to IDLE;
  - the next operation is accepted exactly 1 edge after the output handshake.
- **Single-channel valid:** dividend_tvalid=1 with divisor_tvalid=0 → both treadys stay 0 and nothing is accepted; raising divisor_tvalid then gives acceptance on that edge.
- **Abort paths:**
  - pulse `cancel` at CALC step 10 → IDLE next edge, no tvalid ever;
  - assert `rst` mid-CALC → all outputs at reset values;
  - after either abort, a following `0xFFFFFFFF` / `0x10` unsigned produces `0x0FFFFFFF_0000000F` correctly.

Source files
------------

// File: rtl/axis_div_iter.sv
// axis_div_iter: iterative restoring divider with an AXI-Stream front end.
// Takes one dividend and one divisor together, makes one quotient bit per
// cycle, fixes up the signs, and returns {quotient, remainder}.
//
// state | meaning
// IDLE  | waiting for both operand channels valid together
// CALC  | one restoring shift/subtract step per cycle, WIDTH steps
// FIX   | sign correction and divide-by-zero result selection
// DONE  | result held on m_axis_dout until the consumer takes it
module axis_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cancel,
   input  logic                 signed_op,
   input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
   input  logic                 s_axis_dividend_tvalid,
   output logic                 s_axis_dividend_tready,
   input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
   input  logic                 s_axis_divisor_tvalid,
   output logic                 s_axis_divisor_tready,
   output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
   output logic                 m_axis_dout_tvalid,
   input  logic                 m_axis_dout_tready
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [WIDTH-1:0]     dvd_raw_q, dvd_raw_d;
   logic                 dvs_zero_q, dvs_zero_d;
   logic                 qneg_q, qneg_d;
   logic                 rneg_q, rneg_d;
   logic [2*WIDTH-1:0]   tdata_q, tdata_d;
   logic                 tvalid_q, tvalid_d;

   logic                 accept;
   logic                 sa, sb;
   logic [WIDTH-1:0]     dvd_mag, dvs_mag;
   logic [WIDTH:0]       trial;
   logic [WIDTH-1:0]     q_fix, r_fix;

   // Operand signs only matter for signed ops; magnitudes feed the unsigned core.
   assign sa      = signed_op & s_axis_dividend_tdata[WIDTH-1];
   assign sb      = signed_op & s_axis_divisor_tdata[WIDTH-1];
   assign dvd_mag = sa ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
   assign dvs_mag = sb ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;

   // Shifted partial remainder minus divisor; bit WIDTH set means the step fails.
   // A set MSB in rem_q forces success, so dropping the top bit on success is safe.
   assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
   assign q_fix = qneg_q ? -quo_q : quo_q;
   assign r_fix = rneg_q ? -rem_q : rem_q;

   // State and datapath registers, reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         dvd_raw_q  <= '0;
         dvs_zero_q <= 1'b0;
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         dvd_raw_q  <= dvd_raw_d;
         dvs_zero_q <= dvs_zero_d;
         qneg_q     <= qneg_d;
         rneg_q     <= rneg_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
      end
   end

   // Next-state: cancel aborts CALC/FIX with no result and drops a pending one in DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = CALC;
         CALC: begin
            if (cancel)                  state_d = IDLE;
            else if (cnt_q == LAST_STEP) state_d = FIX;
         end
         FIX:  state_d = cancel ? IDLE : DONE;
         DONE: if (cancel || m_axis_dout_tready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand capture, restoring step, result fix-up and output hold.
   always_comb begin
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      dvd_raw_d  = dvd_raw_q;
      dvs_zero_d = dvs_zero_q;
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
      tdata_d    = tdata_q;
      tvalid_d   = tvalid_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               dvd_raw_d  = s_axis_dividend_tdata;
               dvs_d      = dvs_mag;
               dvs_zero_d = (s_axis_divisor_tdata == '0);
               qneg_d     = sa ^ sb;
               rneg_d     = sa;
               rem_d      = '0;
               quo_d      = dvd_mag;
               cnt_d      = '0;
            end
         end
         CALC: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
         end
         FIX: begin
            // Divide-by-zero returns the raw dividend, not its magnitude.
            if (!cancel) begin
               tdata_d  = dvs_zero_q ? {{WIDTH{1'b1}}, dvd_raw_q} : {q_fix, r_fix};
               tvalid_d = 1'b1;
            end
         end
         DONE: if (cancel || m_axis_dout_tready) tvalid_d = 1'b0;
         default: ;
      endcase
   end

   // Outputs: both input channels are consumed together or not at all.
   always_comb begin
      accept = (state_q == IDLE) & s_axis_dividend_tvalid & s_axis_divisor_tvalid
               & ~cancel & ~rst;
      s_axis_dividend_tready = accept;
      s_axis_divisor_tready  = accept;
      m_axis_dout_tdata      = tdata_q;
      m_axis_dout_tvalid     = tvalid_q;
   end

endmodule

// File: tb/tb_axis_div_iter.sv
// Directed bench for axis_div_iter with a cycle-level reference model.
module tb_axis_div_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cancel = 1'b0;
   logic        sop = 1'b0;
   logic [31:0] dvd = '0, dvs = '0;
   logic        dvd_v = 1'b0, dvs_v = 1'b0;
   logic        dvd_rdy, dvs_rdy;
   logic [63:0] tdata;
   logic        tvalid;
   logic        dout_rdy = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   axis_div_iter #(.WIDTH(32)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .cancel                 (cancel),
      .signed_op              (sop),
      .s_axis_dividend_tdata  (dvd),
      .s_axis_dividend_tvalid (dvd_v),
      .s_axis_dividend_tready (dvd_rdy),
      .s_axis_divisor_tdata   (dvs),
      .s_axis_divisor_tvalid  (dvs_v),
      .s_axis_divisor_tready  (dvs_rdy),
      .m_axis_dout_tdata      (tdata),
      .m_axis_dout_tvalid     (tvalid),
      .m_axis_dout_tready     (dout_rdy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference quotient/remainder from plain 64-bit arithmetic (truncating division).
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint sa, sb, q, r;
      if (b == 32'h0) return {32'hFFFF_FFFF, a};
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'h0, a});
         sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {q[31:0], r[31:0]};
   endfunction

   // Timing model: m_cnt counts edges since acceptance (-1 when not busy).
   int          m_cnt = -1;
   bit          m_valid = 1'b0;
   bit          m_acc = 1'b0;
   logic [63:0] m_tdata = '0;
   logic [63:0] m_res = '0;

   always @(posedge clk) begin
      m_acc = 1'b0;
      if (rst) begin
         m_cnt   = -1;
         m_valid = 1'b0;
         m_tdata = '0;
      end else if (m_valid) begin
         if (cancel || dout_rdy) m_valid = 1'b0;
      end else if (m_cnt >= 0) begin
         if (cancel) m_cnt = -1;
         else begin
            m_cnt++;
            if (m_cnt == 33) begin
               m_valid = 1'b1;
               m_tdata = m_res;
               m_cnt   = -1;
            end
         end
      end else if (dvd_v && dvs_v && !cancel) begin
         m_acc = 1'b1;
         m_cnt = 0;
         m_res = ref_div(dvd, dvs, sop);
      end
   end

   // Every-cycle compare against the model, sampled on the falling edge.
   initial begin
      logic exp_rdy;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_rdy = (m_cnt < 0) && !m_valid && dvd_v && dvs_v && !cancel && !rst;
         check("dividend_tready", {63'h0, dvd_rdy}, {63'h0, exp_rdy});
         check("divisor_tready",  {63'h0, dvs_rdy}, {63'h0, exp_rdy});
         check("tvalid",          {63'h0, tvalid},  {63'h0, m_valid});
         check("tdata",           tdata,            m_tdata);
      end
   end

   // All stimulus tasks start and end 2 time units after a rising edge.
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
      dvd = a; dvs = b; sop = s; dvd_v = 1'b1; dvs_v = 1'b1;
   endtask

   task automatic wait_accept(output int n);
      bit acc = 1'b0;
      n = 0;
      while (!acc && n < 60) begin
         @(posedge clk); #1;
         n++;
         acc = m_acc;
         #1;
      end
      if (!acc) check("accept_timeout", 64'h0, 64'h1);
   endtask

   task automatic wait_valid(output int n);
      bit seen = 1'b0;
      n = 0;
      while (!seen && n < 60) begin
         @(posedge clk); #1;
         n++;
         seen = tvalid;
         #1;
      end
      if (!seen) check("valid_timeout", 64'h0, 64'h1);
   endtask

   task automatic handshake(input int hold, input logic [63:0] exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #2;
         check("bp_tvalid", {63'h0, tvalid}, 64'h1);
         check("bp_tdata", tdata, exp);
      end
      dout_rdy = 1'b1;
      @(posedge clk); #2;
      dout_rdy = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp, input int hold);
      int n;
      drive(a, b, s);
      wait_accept(n);
      dvd_v = 1'b0; dvs_v = 1'b0;
      wait_valid(n);
      check({name, "_latency"}, 64'(n), 64'd33);
      check({name, "_result"}, tdata, exp);
      handshake(hold, exp);
   endtask

   initial begin
      int  n;
      bit  saw;

      // Pin the reference model against hand-computed results.
      check("model_udiv",  ref_div(32'd100, 32'd7, 1'b0),               64'h0000000E_00000002);
      check("model_sdiv1", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1),         64'hFFFFFFFD_FFFFFFFF);
      check("model_sdiv2", ref_div(32'd7, 32'hFFFF_FFFE, 1'b1),         64'hFFFFFFFD_00000001);
      check("model_ovf",   ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 64'h80000000_00000000);
      check("model_div0",  ref_div(32'h1234_5678, 32'h0, 1'b1),         64'hFFFFFFFF_12345678);

      // Reset with inputs valid: nothing accepted, outputs at reset values.
      drive(32'd5, 32'd1, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      check("rst_tvalid", {63'h0, tvalid}, 64'h0);
      check("rst_tdata", tdata, 64'h0);
      check("rst_tready", {63'h0, dvd_rdy | dvs_rdy}, 64'h0);
      dvd_v = 1'b0; dvs_v = 1'b0;
      rst = 1'b0;
      @(posedge clk); #2;

      run_op("udiv",   32'd100,       32'd7,         1'b0, 64'h0000000E_00000002, 0);
      run_op("sdiv1",  32'hFFFF_FFF9, 32'd2,         1'b1, 64'hFFFFFFFD_FFFFFFFF, 1);
      run_op("sdiv2",  32'd7,         32'hFFFF_FFFE, 1'b1, 64'hFFFFFFFD_00000001, 0);
      run_op("div0u",  32'h1234_5678, 32'h0,         1'b0, 64'hFFFFFFFF_12345678, 0);
      run_op("div0s",  32'h1234_5678, 32'h0,         1'b1, 64'hFFFFFFFF_12345678, 0);
      run_op("div0sn", 32'h8765_4321, 32'h0,         1'b1, 64'hFFFFFFFF_87654321, 0);
      run_op("ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h80000000_00000000, 0);

      // Backpressure with the next operands already waiting.
      drive(32'd100, 32'd7, 1'b0);
      wait_accept(n);
      drive(32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_valid(n);
      check("bp_latency", 64'(n), 64'd33);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         check("bp_hold_tdata", tdata, 64'h0000000E_00000002);
         check("bp_hold_tvalid", {63'h0, tvalid}, 64'h1);
         check("bp_hold_tready", {63'h0, dvd_rdy | dvs_rdy}, 64'h0);
      end
      dout_rdy = 1'b1;
      @(posedge clk); #2;
      dout_rdy = 1'b0;
      wait_accept(n);
      check("bp_next_accept_edges", 64'(n), 64'd1);
      dvd_v = 1'b0; dvs_v = 1'b0;
      wait_valid(n);
      check("bp_second_result", tdata, 64'hFFFFFFFD_FFFFFFFF);
      handshake(0, 64'hFFFFFFFD_FFFFFFFF);

      // Only the dividend valid: nothing consumed until the divisor joins.
      dvd = 32'd1000; dvs = 32'd10; sop = 1'b0; dvd_v = 1'b1; dvs_v = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         check("single_tready", {63'h0, dvd_rdy | dvs_rdy}, 64'h0);
      end
      dvs_v = 1'b1;
      wait_accept(n);
      check("single_accept_edges", 64'(n), 64'd1);
      dvd_v = 1'b0; dvs_v = 1'b0;
      wait_valid(n);
      check("single_result", tdata, 64'h00000064_00000000);
      handshake(0, 64'h00000064_00000000);

      // Cancel during DONE drops the pending result.
      drive(32'd9, 32'd4, 1'b0);
      wait_accept(n);
      dvd_v = 1'b0; dvs_v = 1'b0;
      wait_valid(n);
      cancel = 1'b1;
      @(posedge clk); #2;
      cancel = 1'b0;
      check("done_cancel_tvalid", {63'h0, tvalid}, 64'h0);

      // Cancel at CALC step 10: no result ever appears.
      drive(32'hDEAD_BEEF, 32'd3, 1'b0);
      wait_accept(n);
      dvd_v = 1'b0; dvs_v = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      cancel = 1'b1;
      @(posedge clk); #2;
      cancel = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (tvalid) saw = 1'b1;
         #1;
      end
      check("cancel_no_tvalid", {63'h0, saw}, 64'h0);
      run_op("after_cancel", 32'hFFFF_FFFF, 32'h10, 1'b0, 64'h0FFFFFFF_0000000F, 0);

      // Reset mid-CALC with inputs valid.
      drive(32'hDEAD_BEEF, 32'd3, 1'b0);
      wait_accept(n);
      dvd_v = 1'b0; dvs_v = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      drive(32'd50, 32'd5, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_tvalid", {63'h0, tvalid}, 64'h0);
      check("midrst_tdata", tdata, 64'h0);
      check("midrst_tready", {63'h0, dvd_rdy | dvs_rdy}, 64'h0);
      @(posedge clk); #2;
      rst = 1'b0;
      dvd_v = 1'b0; dvs_v = 1'b0;
      @(posedge clk); #2;
      run_op("after_rst", 32'hFFFF_FFFF, 32'h10, 1'b0, 64'h0FFFFFFF_0000000F, 0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
